// File: rtl/rx_frame_slicer.sv
// Oversampling receive slicer: synchronizes InnerReceive, hunts for SYNC_WORD, and streams length-prefixed payload bytes out.
// Optional per-byte even parity (length and payload) is enabled by defining RX_FRAME_PARITY_EN.
module rx_frame_slicer #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter logic [7:0]  SYNC_WORD  = 8'hA7
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       InnerReceive,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic       DataLast,
    input  logic       DataReady,
    output logic       InFrame,
    output logic       Overrun,
    output logic       ParityError
);

    localparam int unsigned    PW           = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0]  PHASE_SAMPLE = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0]  PHASE_LAST   = PW'(OVERSAMPLE - 1);
`ifdef RX_FRAME_PARITY_EN
    localparam logic [3:0]     LAST_BIT     = 4'd8;
`else
    localparam logic [3:0]     LAST_BIT     = 4'd7;
`endif

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    function automatic logic even_par_ok(input logic [7:0] data, input logic par);
        return ((^data) ^ par) == 1'b0;
    endfunction

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    shift_q, shift_d;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          data_last_q, data_last_d;
    logic          in_frame_q, in_frame_d;
    logic          overrun_q, overrun_d;
    logic          parity_err_q, parity_err_d;

    logic          edge_s, sample_s, byte_end_s, par_ok_s, accept_s, emit_s, emit_last_s;
    logic [7:0]    shift_nxt_s, byte_s;

    // Bit recovery, framing FSM and output holding register next-state logic
    always_comb begin
        edge_s      = rx_sync_q ^ rx_prev_q;
        sample_s    = (phase_q == PHASE_SAMPLE);
        shift_nxt_s = {shift_q[6:0], rx_sync_q};
        byte_end_s  = sample_s && (bit_cnt_q == LAST_BIT);
        accept_s    = data_valid_q && DataReady;
`ifdef RX_FRAME_PARITY_EN
        // The parity bit is the one being sampled; the data byte is already in place.
        byte_s      = shift_q;
        par_ok_s    = even_par_ok(shift_q, rx_sync_q);
`else
        byte_s      = shift_nxt_s;
        par_ok_s    = 1'b1;
`endif

        if (edge_s) begin
            phase_d = '0;
        end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PW'(1);
        end

        if (sample_s) begin
            shift_d = shift_nxt_s;
        end else begin
            shift_d = shift_q;
        end

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        in_frame_d   = in_frame_q;
        overrun_d    = overrun_q;
        parity_err_d = 1'b0;
        emit_s       = 1'b0;
        emit_last_s  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (sample_s && (shift_nxt_s == SYNC_WORD)) begin
                    state_d    = ST_LEN;
                    bit_cnt_d  = 4'd0;
                    in_frame_d = 1'b1;
                    overrun_d  = 1'b0;
                end else begin
                    bit_cnt_d  = 4'd0;
                end
            end
            ST_LEN: begin
                if (byte_end_s) begin
                    bit_cnt_d = 4'd0;
                    if (!par_ok_s) begin
                        state_d      = ST_HUNT;
                        in_frame_d   = 1'b0;
                        parity_err_d = 1'b1;
                    end else if (byte_s == 8'd0) begin
                        state_d    = ST_HUNT;
                        in_frame_d = 1'b0;
                    end else begin
                        state_d    = ST_PAYLOAD;
                        byte_cnt_d = byte_s;
                    end
                end else if (sample_s) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_PAYLOAD: begin
                if (byte_end_s) begin
                    bit_cnt_d    = 4'd0;
                    byte_cnt_d   = byte_cnt_q - 8'd1;
                    emit_s       = 1'b1;
                    parity_err_d = !par_ok_s;
                    if (byte_cnt_q == 8'd1) begin
                        emit_last_s = 1'b1;
                        state_d     = ST_HUNT;
                        in_frame_d  = 1'b0;
                    end else begin
                        emit_last_s = 1'b0;
                    end
                end else if (sample_s) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            default: begin
                state_d    = ST_HUNT;
                in_frame_d = 1'b0;
            end
        endcase

        data_out_d   = data_out_q;
        data_last_d  = data_last_q;
        data_valid_d = data_valid_q;
        // A full, unaccepted holding register drops the new byte; framing carries on.
        if (emit_s) begin
            if (!data_valid_q || accept_s) begin
                data_out_d   = byte_s;
                data_last_d  = emit_last_s;
                data_valid_d = 1'b1;
            end else begin
                overrun_d    = 1'b1;
            end
        end else if (accept_s) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rx_meta_q    <= 1'b0;
            rx_sync_q    <= 1'b0;
            rx_prev_q    <= 1'b0;
            phase_q      <= '0;
            shift_q      <= 8'h00;
            state_q      <= ST_HUNT;
            bit_cnt_q    <= 4'd0;
            byte_cnt_q   <= 8'd0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            in_frame_q   <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_meta_q    <= InnerReceive;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            phase_q      <= phase_d;
            shift_q      <= shift_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            in_frame_q   <= in_frame_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign DataOut     = data_out_q;
    assign DataValid   = data_valid_q;
    assign DataLast    = data_last_q;
    assign InFrame     = in_frame_q;
    assign Overrun     = overrun_q;
    assign ParityError = parity_err_q;

endmodule

// File: tb/tb_rx_frame_slicer.sv
// Self-checking bench for rx_frame_slicer: frames are serialized onto InnerReceive (optionally jittered)
// and the delivered bytes are compared with a bit-stream frame parser kept in the bench.
module tb_rx_frame_slicer;

    localparam int OS = 8;
`ifdef RX_FRAME_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       Clock = 1'b0;
    logic       ResetN;
    logic       InnerReceive;
    logic       DataReady;
    logic [7:0] DataOut;
    logic       DataValid, DataLast, InFrame, Overrun, ParityError;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];       // {parity_error, last, data}
    logic [7:0] tx_q[$];
    bit         seg[$];
    bit         cur_line = 1'b0;
    bit         ready_rand = 1'b0;
    bit         ready_val  = 1'b1;
    int         perr_cycles = 0;

    bit         prev_valid = 1'b0, prev_ready = 1'b0, prev_in_frame = 1'b0;
    logic [8:0] prev_data = 9'h000;

    rx_frame_slicer #(.OVERSAMPLE(OS), .SYNC_WORD(8'hA7)) dut (
        .Clock(Clock), .ResetN(ResetN), .InnerReceive(InnerReceive),
        .DataOut(DataOut), .DataValid(DataValid), .DataLast(DataLast),
        .DataReady(DataReady), .InFrame(InFrame), .Overrun(Overrun),
        .ParityError(ParityError)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] read_byte(input bit bits[$], input int pos);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < 8; k++) v = {v[6:0], logic'(bits[pos + k])};
        return v;
    endfunction

    function automatic bit bad_par(input bit bits[$], input int pos);
        if (NB == 9) return bit'((^read_byte(bits, pos)) ^ bits[pos + 8]);
        else return 1'b0;
    endfunction

    // Reference: slide an 8-bit window over the stream, then read length and payload fields.
    function automatic void model_parse(input bit bits[$]);
        logic [7:0] win;
        int         i, n, len;
        win = 8'h00;
        i   = 0;
        n   = bits.size();
        while (i < n) begin
            win = {win[6:0], logic'(bits[i])};
            i++;
            if (win == 8'hA7 && i + NB <= n) begin
                len = int'(read_byte(bits, i));
                if (!bad_par(bits, i) && len != 0) begin
                    i += NB;
                    for (int b = 0; b < len && i + NB <= n; b++) begin
                        exp_q.push_back({logic'(bad_par(bits, i)), logic'(b == len - 1), read_byte(bits, i)});
                        i += NB;
                    end
                end else begin
                    i += NB;
                end
                win = read_byte(bits, i - 8);
            end
        end
    endfunction

    task automatic push_byte(input logic [7:0] b, input bit with_par, input bit bad);
        for (int k = 7; k >= 0; k--) seg.push_back(b[k]);
        if (NB == 9 && with_par) seg.push_back(bit'((^b) ^ bad));
    endtask

    // Edge jitter is drawn in -2..+2 but never shrinks an interval between edges by more than 2 cycles.
    task automatic drive_seg(input bit jitter);
        int st[$];
        int n, pj, lo, j, idx;
        bit prev, first;
        n = seg.size();
        pj = 0;
        prev = cur_line;
        first = 1'b1;
        for (int k = 0; k < n; k++) begin
            j = 0;
            if (jitter && seg[k] != prev) begin
                lo = first ? -2 : pj - 2;
                if (lo < -2) lo = -2;
                j = lo + int'($urandom_range(0, 2 - lo));
                pj = j;
                first = 1'b0;
            end
            st.push_back(2 + OS * k + j);
            prev = seg[k];
        end
        st.push_back(2 + OS * n);
        idx = 0;
        for (int c = 0; c < st[n]; c++) begin
            @(negedge Clock);
            while (idx < n && c >= st[idx]) idx++;
            InnerReceive = (idx == 0) ? cur_line : seg[idx - 1];
        end
        cur_line = InnerReceive;
    endtask

    task automatic send_frame(input int bad_idx, input bit jitter, input int cut_bits);
        seg.delete();
        push_byte(tx_q[0], 1'b0, 1'b0);
        for (int i = 1; i < tx_q.size(); i++) push_byte(tx_q[i], 1'b1, i == bad_idx);
        if (cut_bits > 0) begin
            while (seg.size() > cut_bits) void'(seg.pop_back());
        end else begin
            for (int i = 0; i < 16; i++) seg.push_back(1'b0);
        end
        model_parse(seg);
        drive_seg(jitter);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 3000 && (exp_q.size() != 0 || DataValid); c++) @(negedge Clock);
        check_val("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Consumer ready, updated just after each rising edge
    initial begin
        DataReady = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            DataReady = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    // Output monitor: new-byte qualifiers, hold stability, and handshake scoreboard
    initial begin
        forever begin
            @(negedge Clock);
            if (ResetN) begin
                if (ParityError) perr_cycles++;
                if (prev_valid && !prev_ready)
                    check_val("hold", {DataValid, DataLast, DataOut}, {1'b1, prev_data});
                if (DataValid && (!prev_valid || prev_ready) && exp_q.size() != 0) begin
                    check_val("perr_at_load", ParityError, exp_q[0][9]);
                    check_val("inframe_at_load", {InFrame, prev_in_frame}, exp_q[0][8] ? 2'b01 : 2'b11);
                end
                if (DataValid && DataReady) begin
                    if (exp_q.size() == 0) check_val("unexpected_byte", 32'(exp_q.size()), 32'd1);
                    else check_val("byte", {DataLast, DataOut}, exp_q.pop_front()[8:0]);
                end
                prev_valid    = DataValid;
                prev_ready    = DataReady;
                prev_data     = {DataLast, DataOut};
                prev_in_frame = InFrame;
            end else begin
                prev_valid    = 1'b0;
                prev_ready    = 1'b0;
                prev_in_frame = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int len, base;
        ResetN = 1'b1;
        InnerReceive = 1'b0;
        #1 ResetN = 1'b0;
        repeat (3) @(negedge Clock);
        check_val("rst_dataout", DataOut, 8'h00);
        check_val("rst_flags", {DataValid, DataLast, InFrame, Overrun, ParityError}, 5'b0);
        ResetN = 1'b1;
        repeat (40) @(negedge Clock);

        tx_q = {8'hA7, 8'h03, 8'h11, 8'h22, 8'h33};
        send_frame(-1, 1'b0, 0);
        wait_drain();
        check_val("idle_inframe", InFrame, 1'b0);

        tx_q = {8'hA7, 8'h00};
        send_frame(-1, 1'b0, 0);
        wait_drain();
        check_val("len0_inframe", InFrame, 1'b0);
        tx_q = {8'hA7, 8'h01, 8'h5C};
        send_frame(-1, 1'b0, 0);
        wait_drain();

        ready_val = 1'b0;
        tx_q = {8'hA7, 8'h02, 8'h44, 8'h55};
        send_frame(-1, 1'b0, 0);
        // 0x55 completes while 0x44 is still held, so it is lost
        if (exp_q.size() > 1) exp_q.delete(1);
        check_val("ovr_hold", {DataValid, DataLast, DataOut}, {2'b10, 8'h44});
        check_val("ovr_set", Overrun, 1'b1);
        ready_val = 1'b1;
        wait_drain();
        check_val("ovr_sticky", Overrun, 1'b1);
        tx_q = {8'hA7, 8'h01, 8'h9E};
        send_frame(-1, 1'b0, 0);
        wait_drain();
        check_val("ovr_cleared", Overrun, 1'b0);

        ready_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            len = int'($urandom_range(0, 4));
            tx_q = {8'hA7, 8'(len)};
            for (int b = 0; b < len; b++) tx_q.push_back(8'($urandom_range(0, 255)));
            send_frame(-1, f[0], 0);
            wait_drain();
        end
        ready_rand = 1'b0;
        ready_val = 1'b1;

        tx_q = {8'hA7, 8'h04, 8'hC3, 8'h5A, 8'h77, 8'hE1};
        send_frame(-1, 1'b0, 8 + 2 * NB + 4);
        #2 ResetN = 1'b0;
        #1;
        check_val("mid_rst_dataout", DataOut, 8'h00);
        check_val("mid_rst_flags", {DataValid, DataLast, InFrame, Overrun, ParityError}, 5'b0);
        check_val("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        InnerReceive = 1'b0;
        cur_line = 1'b0;
        repeat (5) @(negedge Clock);
        ResetN = 1'b1;
        repeat (20) @(negedge Clock);
        tx_q = {8'hA7, 8'h01, 8'h9E};
        send_frame(-1, 1'b0, 0);
        wait_drain();

`ifdef RX_FRAME_PARITY_EN
        base = perr_cycles;
        tx_q = {8'hA7, 8'h01, 8'h0F};
        send_frame(2, 1'b0, 0);
        wait_drain();
        check_val("perr_payload_pulse", 32'(perr_cycles - base), 32'd1);
        base = perr_cycles;
        tx_q = {8'hA7, 8'h02, 8'h44, 8'h55};
        send_frame(1, 1'b0, 0);
        wait_drain();
        check_val("perr_len_pulse", 32'(perr_cycles - base), 32'd1);
        check_val("perr_len_inframe", InFrame, 1'b0);
`else
        base = perr_cycles;
        check_val("perr_tied_low", 32'(base), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_slicer.md
# rx_frame_slicer

Digital receive-side slicer placed directly downstream of the post-LNA stage. It consumes the single-ended InnerReceive line, recovers bit timing by oversampling, hunts for a sync word, and delivers the length-prefixed frame payload as bytes over a valid/ready handshake to the inner receive logic.

## Interface
Parameters:
- OVERSAMPLE, 8, clock cycles per received bit; legal range 4..64.
- SYNC_WORD, 8'hA7, 8-bit frame sync pattern, MSB first.

Ports:
- Clock  input  1  single system clock, rising edge.
- ResetN  input  1  reset, asynchronous and active-low.
- InnerReceive  input  1  raw receive line from the post-LNA stage, asynchronous to Clock.
- DataOut  output  8  payload byte.
- DataValid  output  1  DataOut holds a byte.
- DataLast  output  1  qualifies DataValid; final byte of the frame.
- DataReady  input  1  consumer accepts the byte when DataValid && DataReady.
- InFrame  output  1  high from sync match until the last payload bit is sampled.
- Overrun  output  1  sticky; a completed byte was dropped.
- ParityError  output  1  one-cycle pulse; see Configuration.

## Operation
- Input path: InnerReceive passes a 2-flop synchronizer; an edge detector compares the synchronized value with its one-cycle-delayed copy.
- Bit timing: phase counter 0..OVERSAMPLE-1 increments each cycle and wraps. The counter is forced to 0 on the cycle after a detected edge. A bit is sampled when phase == OVERSAMPLE/2.
- Sampled bits shift into an 8-bit register, MSB first.
- FSM states:
  - HUNT: every sampled bit, compare the shift register with SYNC_WORD. On a match, go to LEN, clear Overrun, assert InFrame.
  - LEN: after 8 bits, latch the length L (0..255). If L == 0, go to HUNT with InFrame low and emit no byte. Otherwise go to PAYLOAD with the byte counter set to L.
  - PAYLOAD: every 8 bits completes a byte and decrements the counter. At counter 1, mark the byte last, go to HUNT and deassert InFrame.
- Bit counter resets on each state entry. The sync match in HUNT is tested on a sliding window; bits from LEN/PAYLOAD are not tested for sync.
- Output holding register, single entry:
  - A completed byte loads DataOut/DataLast and sets DataValid when the register is empty, or when it is being accepted in the same cycle.
  - If the register is full and not being accepted, the new byte is dropped and Overrun is set. The FSM continues regardless.
  - DataOut and DataLast are stable while DataValid && !DataReady.
- Reset mid-frame: all state is cleared immediately and the FSM returns to HUNT. A partially delivered frame is not resumed.

## Timing
- Reset values: DataOut=0, DataValid=0, DataLast=0, InFrame=0, Overrun=0, ParityError=0, FSM=HUNT, phase=0, shift register=0.
- Latency from an InnerReceive edge to the internal edge detect: 3 cycles.
- Byte completion to DataValid high: 1 cycle (registered).
- DataValid falls on the cycle after the handshake, unless a new byte loads on that same cycle.
- Back-to-back acceptance sustains 1 byte per 8·OVERSAMPLE cycles, or 9·OVERSAMPLE with parity.
- InFrame rises 1 cycle after the sampling cycle of the final sync bit. It falls 1 cycle after the final payload bit is sampled.

## Configuration
- Macro: RX_FRAME_PARITY_EN.
  - Defined: each length and payload byte is followed by one even-parity bit (the 9 bits XOR to 0). The byte completes after the parity bit.
    - Mismatch on a payload byte: the byte is still delivered, and ParityError pulses high for 1 cycle coincident with the DataValid rise for that byte.
    - Mismatch on the length byte: the FSM returns to HUNT, no bytes are emitted, and ParityError pulses 1 cycle.
  - Undefined: no parity bits exist and ParityError is tied 0.

## Test plan
- OVERSAMPLE=8, stream A7, 03, 11, 22, 33 with DataReady=1 -> bytes 11, 22, 33 on DataOut; DataLast only with 33; InFrame low 1 cycle after the last bit.
- Stream A7, 00 -> no DataValid; FSM back in HUNT; a following A7, 01, 5C yields a single byte 5C with DataLast=1.
- DataReady=0 throughout a frame A7, 02, 44, 55 -> DataOut holds 44 stably; Overrun=1 after 55 completes; Overrun clears on the next sync match.
- Input edges jittered ±2 cycles around nominal bit boundaries -> identical payload recovered.
- ResetN asserted low mid-payload -> all outputs 0 asynchronously; a fresh A7, 01, 9E after release yields 9E.
- With RX_FRAME_PARITY_EN: payload byte 0F sent with parity 1 (wrong) -> 0F delivered with a 1-cycle ParityError pulse; bad parity on the length byte -> no output and a return to HUNT.
